cur_blk_fetch: RTL and testbench
================================

Name: cur_blk_fetch

Overview:
- Initiator-side fetch engine for the current-frame pixel memory.
- Drives the memory's enable/address pair and captures the 64-bit little-endian 8-pixel read word.
- Assembles one 16x16 current macroblock row by row (two 64-bit reads per row).
- Presents each 128-bit row to the ME array over a valid/ready handshake, with backpressure.

Parameters:
- FRAME_WIDTH, 1920: luma pixels per frame row (bytes per line in memory).
- BASE_ADDR, 0: byte address of pixel (0,0) of the current frame.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request fetch of block (blk_x, blk_y); sampled only in IDLE.
- blk_x  input  8  macroblock column index.
- blk_y  input  8  macroblock row index.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last row handshake.
- mem_en  output  1  read enable to the current-frame memory.
- mem_addr  output  32  byte address of the 8-byte read word.
- mem_data  input  64  read word; byte k = pixel at mem_addr+k; valid in the same cycle as mem_addr (combinational memory).
- row_valid  output  1  row_data holds a complete row.
- row_ready  input  1  consumer accepts the row.
- row_data  output  128  16 pixels; [7:0] = leftmost pixel.
- row_idx  output  4  row number 0..15 of row_data.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, mem_en, row_valid = 0. mem_addr, row_data, row_idx = 0. Counters cleared. A reset mid-block abandons the block; no done is produced.
- States: IDLE, FETCH_LO, FETCH_HI, OUT.
- IDLE: start=1 at edge E latches blk_x/blk_y and computes the row base: BASE_ADDR + (blk_y*16)*FRAME_WIDTH + blk_x*16. Arithmetic is 32-bit modulo 2^32.
  - After E: FETCH_LO, busy=1, mem_en=1, mem_addr=row base, row counter=0.
- FETCH_LO: at the next edge, capture mem_data into row_data[63:0]; mem_addr += 8; go to FETCH_HI.
- FETCH_HI: at the next edge, capture mem_data into row_data[127:64]; mem_en=0; row_valid=1; row_idx=row counter; go to OUT.
- OUT: hold row_valid, row_data and row_idx stable while row_ready=0. mem_en stays 0.
  - Handshake (row_valid & row_ready at an edge), row <15: row_valid=0; row counter+1; mem_addr = previous row base + FRAME_WIDTH; mem_en=1; go to FETCH_LO.
  - Handshake, row 15: row_valid=0; busy=0; done=1 for one cycle; go to IDLE.
- Latency with row_ready tied high: first row_valid after edge E+2. One row every 3 cycles. done is high in the cycle after edge E+48.
- start while busy: ignored. start in the done cycle: accepted (state is already IDLE).
- blk_x/blk_y are sampled only at acceptance; later changes have no effect.
- row_data keeps its last value in IDLE.
- mem_addr is 0 whenever mem_en=0 except in OUT, where it holds its last value (don't-care to the memory).

Optional Feature:
- Macro CUR_BLK_FETCH_CHECKSUM_EN.
- Defined:
  - Adds output blk_sum [15:0]: unsigned sum of all 256 pixels of the block.
  - Cleared on start acceptance; accumulates each row's 16 pixels on its handshake.
  - Valid and stable from the done cycle until the next start. Reset value 0.
  - Cannot overflow: max 65280.
- Undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Memory init mem[i]=i[7:0]; FRAME_WIDTH=1920; block (0,0); row_ready=1.
  - Row 0 addresses 0 then 8; row_data = 128'h0f0e0d0c0b0a09080706050403020100.
  - Row 1 addresses 1920 and 1928; row_data = 128'h8f8e...8180.
  - done in the cycle after edge E+48.
- Block (2,1): first mem_addr = 30752, second = 30760; row 15 base = 59552.
- Backpressure: hold row_ready=0 for 5 cycles on row 3 -> row_valid=1, row_data and row_idx=3 stable; mem_en=0 throughout; fetch of row 4 starts after the handshake edge.
- start pulsed at row 7 of an active block -> ignored: no address jump, one done only. start in the done cycle -> new block accepted; mem_en=1 the next cycle.
- rst_n driven low during FETCH_HI of row 5 -> all outputs 0 immediately; no done pulse. After release, a new start fetches normally from row 0.
- With CUR_BLK_FETCH_CHECKSUM_EN, block (0,0), memory as in scenario 1 -> blk_sum = 18304 at done.

Source files
------------

// File: rtl/cur_blk_fetch_if.sv
// Fetch-engine bus: current-frame memory read port plus the row handshake to the ME array.
interface cur_blk_fetch_if;
  logic         mem_en;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_data;
  logic         row_valid;
  logic         row_ready;
  logic [127:0] row_data;
  logic [3:0]   row_idx;

  modport master (output mem_en, mem_addr, row_valid, row_data, row_idx,
                  input  mem_data, row_ready);
  modport slave  (input  mem_en, mem_addr, row_valid, row_data, row_idx,
                  output mem_data, row_ready);
endinterface

// File: rtl/cur_blk_fetch.sv
// Current-macroblock fetch: two 64-bit reads per row, 16 rows, valid/ready row output.
// Optional block checksum output enabled by CUR_BLK_FETCH_CHECKSUM_EN.
module cur_blk_fetch #(
  parameter int unsigned FRAME_WIDTH = 1920,
  parameter logic [31:0] BASE_ADDR   = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] blk_x,
  input  logic [7:0] blk_y,
  output logic       busy,
  output logic       done,
  cur_blk_fetch_if.master bus
`ifdef CUR_BLK_FETCH_CHECKSUM_EN
  , output logic [15:0] blk_sum
`endif
);

  localparam logic [31:0] FW = 32'(FRAME_WIDTH);

  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] row_base;
  logic [31:0] base_calc;
  logic [3:0]  row_cnt;
  logic        hs;
  logic        last_row;

  assign base_calc = BASE_ADDR + (({24'd0, blk_y} << 4) * FW) + ({24'd0, blk_x} << 4);
  assign hs        = bus.row_valid & bus.row_ready;
  assign last_row  = (row_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FETCH_LO;
      FETCH_LO: state_nxt = FETCH_HI;
      FETCH_HI: state_nxt = OUT;
      OUT:      if (hs) state_nxt = last_row ? IDLE : FETCH_LO;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.row_valid <= 1'b0;
      bus.row_data  <= '0;
      bus.row_idx   <= '0;
      row_base      <= '0;
      row_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          row_base     <= base_calc;
          bus.mem_addr <= base_calc;
          bus.mem_en   <= 1'b1;
          busy         <= 1'b1;
          row_cnt      <= '0;
        end
        FETCH_LO: begin
          bus.row_data[63:0] <= bus.mem_data;
          bus.mem_addr       <= bus.mem_addr + 32'd8;
        end
        FETCH_HI: begin
          bus.row_data[127:64] <= bus.mem_data;
          bus.mem_en           <= 1'b0;
          bus.row_valid        <= 1'b1;
          bus.row_idx          <= row_cnt;
        end
        OUT: if (hs) begin
          bus.row_valid <= 1'b0;
          if (last_row) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            bus.mem_addr <= '0;
          end else begin
            row_cnt      <= row_cnt + 4'd1;
            row_base     <= row_base + FW;
            bus.mem_addr <= row_base + FW;
            bus.mem_en   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CUR_BLK_FETCH_CHECKSUM_EN
  logic [15:0] row_sum;

  always_comb begin
    row_sum = '0;
    for (int k = 0; k < 16; k++) row_sum = row_sum + 16'(bus.row_data[8*k +: 8]);
  end

  // 256 pixels * 255 max fits in 16 bits, so no saturation needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      blk_sum <= '0;
    else if (state == IDLE && start) blk_sum <= '0;
    else if (state == OUT && hs)     blk_sum <= blk_sum + row_sum;
  end
`endif

endmodule

// File: tb/tb_cur_blk_fetch.sv
// Directed bench for cur_blk_fetch with a combinational byte-ramp memory (byte at addr = addr[7:0]).
module tb_cur_blk_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] blk_x = '0;
  logic [7:0] blk_y = '0;
  logic       busy, done;
`ifdef CUR_BLK_FETCH_CHECKSUM_EN
  logic [15:0] blk_sum;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  cur_blk_fetch_if bus();

  cur_blk_fetch #(.FRAME_WIDTH(1920), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_x(blk_x), .blk_y(blk_y),
    .busy(busy), .done(done), .bus(bus.master)
`ifdef CUR_BLK_FETCH_CHECKSUM_EN
    , .blk_sum(blk_sum)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_data = '0;
    for (int k = 0; k < 8; k++) bus.mem_data[8*k +: 8] = 8'(bus.mem_addr + 32'(k));
  end

  function automatic logic [127:0] exp_row(input logic [31:0] a);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(a + 32'(k));
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.row_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bus.mem_en, bus.row_valid, bus.mem_addr, bus.row_idx} !== 40'd0 || bus.row_data !== '0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b en=%b valid=%b addr=%0d idx=%0d data=%h, expected all 0",
               busy, done, bus.mem_en, bus.row_valid, bus.mem_addr, bus.row_idx, bus.row_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_block00();
    logic [31:0] b;
    int r;
    bus.row_ready = 1'b1;
    blk_x = 8'd0; blk_y = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 48; c++) begin
      r = c / 3;
      b = 32'(r * 1920);
      n_checks++;
      case (c % 3)
        0: if ({busy, bus.mem_en, bus.row_valid, bus.mem_addr} !== {3'b110, b}) begin
          n_fail++;
          $display("FAIL b00_lo c=%0d: got busy=%b en=%b valid=%b addr=%0d, expected 1 1 0 %0d",
                   c, busy, bus.mem_en, bus.row_valid, bus.mem_addr, b);
        end
        1: if ({bus.mem_en, bus.mem_addr} !== {1'b1, b + 32'd8}) begin
          n_fail++;
          $display("FAIL b00_hi c=%0d: got en=%b addr=%0d, expected 1 %0d", c, bus.mem_en, bus.mem_addr, b + 32'd8);
        end
        default: if (bus.mem_en !== 1'b0 || bus.row_valid !== 1'b1 || bus.row_idx !== 4'(r) ||
                     bus.row_data !== exp_row(b)) begin
          n_fail++;
          $display("FAIL b00_row c=%0d: got en=%b valid=%b idx=%0d data=%h, expected 0 1 %0d %h",
                   c, bus.mem_en, bus.row_valid, bus.row_idx, bus.row_data, r, exp_row(b));
        end
      endcase
      if (c == 2) begin
        n_checks++;
        if (bus.row_data !== 128'h0f0e0d0c0b0a09080706050403020100) begin
          n_fail++; $display("FAIL b00_row0_lit: got %h", bus.row_data);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (bus.mem_addr !== 32'd1928) begin
          n_fail++; $display("FAIL b00_row1_addr: got %0d, expected 1928", bus.mem_addr);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (bus.row_data !== 128'h8f8e8d8c8b8a89888786858483828180) begin
          n_fail++; $display("FAIL b00_row1_lit: got %h", bus.row_data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, busy, bus.mem_en, bus.row_valid, bus.mem_addr} !== {4'b1000, 32'd0}) begin
      n_fail++;
      $display("FAIL b00_done: got done=%b busy=%b en=%b valid=%b addr=%0d, expected 1 0 0 0 0",
               done, busy, bus.mem_en, bus.row_valid, bus.mem_addr);
    end
`ifdef CUR_BLK_FETCH_CHECKSUM_EN
    n_checks++;
    if (blk_sum !== 16'd18304) begin
      n_fail++; $display("FAIL checksum: got %0d, expected 18304", blk_sum);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL b00_done_pulse: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_block21();
    blk_x = 8'd2; blk_y = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0; blk_x = 8'd9; blk_y = 8'd7;
    for (int c = 0; c < 48; c++) begin
      if (c == 0 || c == 1 || c == 45) begin
        n_checks++;
        if (bus.mem_addr !== (c == 0 ? 32'd30752 : c == 1 ? 32'd30760 : 32'd59552)) begin
          n_fail++; $display("FAIL b21_addr c=%0d: got %0d", c, bus.mem_addr);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL b21_done: got done=%b, expected 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    logic ok;
    blk_x = 8'd0; blk_y = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    held = bus.row_data;
    n_checks++;
    if (bus.row_valid !== 1'b1 || bus.row_idx !== 4'd3 || held !== exp_row(32'd5760)) begin
      n_fail++; $display("FAIL bp_row3: got valid=%b idx=%0d data=%h", bus.row_valid, bus.row_idx, held);
    end
    bus.row_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.row_valid !== 1'b1 || bus.row_idx !== 4'd3 || bus.row_data !== held || bus.mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold i=%0d: got valid=%b idx=%0d en=%b data=%h, expected 1 3 0 %h",
                 i, bus.row_valid, bus.row_idx, bus.mem_en, bus.row_data, held);
      end
    end
    bus.row_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_en, bus.row_valid, bus.mem_addr} !== {2'b10, 32'd7680}) begin
      n_fail++;
      $display("FAIL bp_row4: got en=%b valid=%b addr=%0d, expected 1 0 7680", bus.mem_en, bus.row_valid, bus.mem_addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); if (done) ok = 1'b1; end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_done: got no done, expected done within 100 cycles"); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones;
    blk_x = 8'd0; blk_y = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (21) @(negedge clk);
    start = 1'b1; blk_x = 8'd5;
    @(negedge clk); start = 1'b0; blk_x = 8'd0;
    n_checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'd13448}) begin
      n_fail++; $display("FAIL ign_addr: got en=%b addr=%0d, expected 1 13448", bus.mem_en, bus.mem_addr);
    end
    dones = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (done) dones++; end
    n_checks++;
    if (dones != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_done: got dones=%0d busy=%b, expected 1 0", dones, busy);
    end
  endtask

  task automatic test_done_restart();
    logic ok;
    blk_x = 8'd0; blk_y = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); if (done) ok = 1'b1; end
    blk_x = 8'd2; blk_y = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (!ok || {busy, bus.mem_en, bus.mem_addr} !== {2'b11, 32'd30752}) begin
      n_fail++;
      $display("FAIL restart: got done_seen=%b busy=%b en=%b addr=%0d, expected 1 1 1 30752",
               ok, busy, bus.mem_en, bus.mem_addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); if (done) ok = 1'b1; end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL restart_done: got no done, expected done within 100 cycles"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    blk_x = 8'd0; blk_y = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (16) @(negedge clk);
    n_checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'd9608}) begin
      n_fail++; $display("FAIL rst_pre: got en=%b addr=%0d, expected 1 9608", bus.mem_en, bus.mem_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.mem_en, bus.row_valid, bus.mem_addr, bus.row_idx} !== 40'd0 || bus.row_data !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got busy=%b en=%b valid=%b addr=%0d idx=%0d data=%h, expected all 0",
               busy, bus.mem_en, bus.row_valid, bus.mem_addr, bus.row_idx, bus.row_data);
    end
    seen = 1'b0;
    repeat (2) begin @(negedge clk); if (done) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rst_no_done: got done/busy after reset, expected none"); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL rst_refetch: got en=%b addr=%0d, expected 1 0", bus.mem_en, bus.mem_addr);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.row_valid !== 1'b1 || bus.row_idx !== 4'd0 || bus.row_data !== exp_row(32'd0)) begin
      n_fail++; $display("FAIL rst_row0: got valid=%b idx=%0d data=%h", bus.row_valid, bus.row_idx, bus.row_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); if (done) seen = 1'b1; end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_done: got no done, expected done within 100 cycles"); end
  endtask

  initial begin
    bus.row_ready = 1'b1;
    test_reset();
    test_block00();
    test_block21();
    test_backpressure();
    test_start_ignored();
    test_done_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
